player_motion: RTL and testbench

Downstream consumer of the keypad input controller's move_left/right/up/down levels and start_game pulse. Owns the player ship position and the top-level game state (idle / playing / over). Movement is rate-limited by a frame-tick divider and clamped to the screen. Registered x/y feed the renderer and the collision logic; the collision logic returns `hit`.

---
 rtl/player_motion.sv | 145 ++++++++++++++
 tb/tb_player_motion.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// Player ship position and top-level game state (idle / playing / over).
// Movement is rate-limited by a frame-tick divider and clamped to the screen.
module player_motion #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned SHIP_W   = 16,
    parameter int unsigned SHIP_H   = 16,
    parameter int unsigned STEP     = 4,
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned START_X  = 312,
    parameter int unsigned START_Y  = 440
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       start_game,
    input  logic       hit,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       playing,
    output logic       game_over,
    output logic       moved
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPlaying = 2'd1;
    localparam logic [1:0] StOver    = 2'd2;

    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
    localparam logic [10:0]     StepV   = 11'(STEP);
    localparam logic [10:0]     XMax    = 11'(SCREEN_W - SHIP_W);
    localparam logic [10:0]     YMax    = 11'(SCREEN_H - SHIP_H);
    localparam logic [9:0]      StartX  = 10'(START_X);
    localparam logic [9:0]      StartY  = 10'(START_Y);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic            playing_q, playing_d;
    logic            over_q, over_d;
    logic            moved_q, moved_d;

    logic            tick;
    logic [10:0]     x_ext, y_ext;
    logic [10:0]     x_lo, x_hi, y_lo, y_hi;
    logic [9:0]      x_mv, y_mv;

    assign tick  = (cnt_q == CntLast);
    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};

    // Candidate clamped positions for each axis; opposing or idle inputs hold position.
    always_comb begin
        x_lo = (x_ext >= StepV) ? (x_ext - StepV) : 11'd0;
        x_hi = ((x_ext + StepV) <= XMax) ? (x_ext + StepV) : XMax;
        y_lo = (y_ext >= StepV) ? (y_ext - StepV) : 11'd0;
        y_hi = ((y_ext + StepV) <= YMax) ? (y_ext + StepV) : YMax;

        x_mv = x_q;
        case ({move_left, move_right})
            2'b10:   x_mv = x_lo[9:0];
            2'b01:   x_mv = x_hi[9:0];
            default: x_mv = x_q;
        endcase

        y_mv = y_q;
        case ({move_up, move_down})
            2'b10:   y_mv = y_lo[9:0];
            2'b01:   y_mv = y_hi[9:0];
            default: y_mv = y_q;
        endcase
    end

    // Game FSM, tick divider and position next-state.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        moved_d = 1'b0;
        cnt_d   = tick ? '0 : (cnt_q + 1'b1);

        case (state_q)
            StIdle, StOver: begin
                if (start_game) begin
                    state_d = StPlaying;
                    x_d     = StartX;
                    y_d     = StartY;
                    // Restart the divider so the first move lands TICK_DIV cycles later.
                    cnt_d   = '0;
                end
            end
            StPlaying: begin
                if (hit) begin
                    state_d = StOver;
                end else if (tick) begin
                    x_d     = x_mv;
                    y_d     = y_mv;
                    moved_d = (x_mv != x_q) || (y_mv != y_q);
                end
            end
            default: begin
                state_d = StIdle;
                x_d     = StartX;
                y_d     = StartY;
            end
        endcase

        playing_d = (state_d == StPlaying);
        over_d    = (state_d == StOver);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            x_q       <= StartX;
            y_q       <= StartY;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
            moved_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            playing_q <= playing_d;
            over_q    <= over_d;
            moved_q   <= moved_d;
        end
    end

    assign player_x  = x_q;
    assign player_y  = y_q;
    assign playing   = playing_q;
    assign game_over = over_q;
    assign moved     = moved_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion with TICK_DIV=4.
module tb_player_motion;

    logic       clk;
    logic       reset;
    logic       move_left, move_right, move_up, move_down;
    logic       start_game, hit;
    logic [9:0] player_x, player_y;
    logic       playing, game_over, moved;

    int passed = 0;
    int total  = 0;

    player_motion #(
        .TICK_DIV(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .move_left (move_left),
        .move_right(move_right),
        .move_up   (move_up),
        .move_down (move_down),
        .start_game(start_game),
        .hit       (hit),
        .player_x  (player_x),
        .player_y  (player_y),
        .playing   (playing),
        .game_over (game_over),
        .moved     (moved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, l, r, u, d, st, h;
        logic [9:0] x, y;
        logic       p, o, m;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input logic rst_n, input logic l, input logic r, input logic u,
                       input logic d, input logic st, input logic h, input int x,
                       input int y, input logic p, input logic o, input logic m);
        vecs[nvec].rst_n = rst_n; vecs[nvec].l = l; vecs[nvec].r = r;
        vecs[nvec].u = u; vecs[nvec].d = d; vecs[nvec].st = st; vecs[nvec].h = h;
        vecs[nvec].x = 10'(x); vecs[nvec].y = 10'(y);
        vecs[nvec].p = p; vecs[nvec].o = o; vecs[nvec].m = m;
        nvec++;
    endtask

    task automatic drive(input logic rst_n, input logic l, input logic r, input logic u,
                         input logic d, input logic st, input logic h);
        reset = rst_n; move_left = l; move_right = r; move_up = u; move_down = d;
        start_game = st; hit = h;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else passed++;
    endtask

    // Advance n cycles with the current inputs, counting moved pulses.
    task automatic run(input int n, output int moves);
        moves = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (moved === 1'b1) moves++;
        end
    endtask

    task automatic chk_state(input string name, input int x, input int y, input int p,
                             input int o);
        chk({name, "_x"}, int'(player_x), x);
        chk({name, "_y"}, int'(player_y), y);
        chk({name, "_playing"}, int'(playing), p);
        chk({name, "_over"}, int'(game_over), o);
    endtask

    int mv;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset, idle with right held, start, then right held for 12 cycles.
        add(0, 0, 0, 0, 0, 0, 0, 312, 440, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 312, 440, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 0, 1, 0, 0, 0, 0, 312, 440, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0, 312, 440, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            int xe;
            xe = 312 + 4 * (k / 4);
            add(1, 0, 1, 0, 0, 0, 0, xe, 440, 1, 0, (k % 4) == 0);
        end

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].rst_n, vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, vecs[i].st,
                  vecs[i].h);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_x", i), int'(player_x), int'(vecs[i].x));
            chk($sformatf("vec%0d_y", i), int'(player_y), int'(vecs[i].y));
            chk($sformatf("vec%0d_playing", i), int'(playing), int'(vecs[i].p));
            chk($sformatf("vec%0d_over", i), int'(game_over), int'(vecs[i].o));
            chk($sformatf("vec%0d_moved", i), int'(moved), int'(vecs[i].m));
        end

        // Divider is now aligned: every 4 cycles ends on a tick. x=324, y=440.
        drive(1, 0, 0, 0, 1, 0, 0);
        run(24, mv);
        chk_state("down6", 324, 464, 1, 0);
        chk("down6_moves", mv, 6);
        run(8, mv);
        chk_state("down_clamp", 324, 464, 1, 0);
        chk("down_clamp_moves", mv, 0);

        drive(1, 1, 0, 0, 0, 0, 0);
        run(81 * 4, mv);
        chk_state("left81", 0, 464, 1, 0);
        chk("left81_moves", mv, 81);
        run(8, mv);
        chk("left_clamp_x", int'(player_x), 0);
        chk("left_clamp_moves", mv, 0);

        drive(1, 0, 1, 0, 0, 0, 0);
        run(156 * 4, mv);
        chk_state("right156", 624, 464, 1, 0);
        chk("right156_moves", mv, 156);
        run(8, mv);
        chk("right_clamp_x", int'(player_x), 624);
        chk("right_clamp_moves", mv, 0);

        // Opposing horizontal inputs, alone and with up held.
        drive(1, 1, 1, 0, 0, 0, 0);
        run(8, mv);
        chk_state("lr_both", 624, 464, 1, 0);
        chk("lr_both_moves", mv, 0);
        drive(1, 1, 1, 1, 0, 0, 0);
        run(20, mv);
        chk_state("lr_up", 624, 444, 1, 0);
        chk("lr_up_moves", mv, 5);

        // Hit coinciding with a tick while moving left: no move, game over.
        drive(1, 1, 0, 0, 0, 0, 0);
        run(3, mv);
        chk("prehit_x", int'(player_x), 624);
        drive(1, 1, 0, 0, 0, 0, 1);
        run(1, mv);
        chk_state("hit_tick", 624, 444, 0, 1);
        chk("hit_tick_moved", int'(moved), 0);
        run(12, mv);
        chk_state("over_frozen", 624, 444, 0, 1);
        chk("over_frozen_moves", mv, 0);
        drive(1, 1, 0, 0, 0, 1, 1);
        run(1, mv);
        chk_state("restart", 312, 440, 1, 0);

        // Move to x=300, then reset on a tick edge.
        drive(1, 1, 0, 0, 0, 0, 0);
        run(12, mv);
        chk_state("left3", 300, 440, 1, 0);
        chk("left3_moves", mv, 3);
        run(3, mv);
        chk("prereset_x", int'(player_x), 300);
        drive(0, 1, 0, 0, 0, 0, 0);
        run(1, mv);
        chk_state("reset_tick", 312, 440, 0, 0);
        chk("reset_tick_moved", int'(moved), 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        run(8, mv);
        chk_state("idle_after_reset", 312, 440, 0, 0);
        chk("idle_after_reset_moves", mv, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
